// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the staged reset sequencer.
//   - seq_state_e : FSM state encoding (HOLD / RELEASE / IDLE)
//   - stage_w()   : width of the "stages released" count for a given stage count
//   - MIN_STAGES / MAX_STAGES : legal range of NUM_STAGES
// Optional feature macro used by the top: RESET_SEQ_REQ_SYNC_EN
// -----------------------------------------------------------------------------
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_IDLE    = 2'd2
   } seq_state_e;

   localparam int MIN_STAGES = 1;
   localparam int MAX_STAGES = 16;

   // stage_o has to represent 0 .. num_stages inclusive.
   function automatic int stage_w(input int num_stages);
      return $clog2(num_stages + 1);
   endfunction

   localparam int STAGE_W_MAX = $clog2(MAX_STAGES + 1);

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit double-flop synchronizer with synchronous active-high reset.
// Ports:
//   clk  in   destination clock
//   rst  in   synchronous active-high reset, both flops clear to 0
//   d_i  in   asynchronous (foreign-domain) input
//   q_o  out  synchronized output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Drives staged, ordered reset releases for NUM_STAGES downstream blocks.
// All stage resets are held asserted for HOLD_CYCLES, then released one per
// GAP_CYCLES in ascending index order. A request (req_i) re-runs the sequence.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset of the sequencer
//   req_i    in   level-sensitive reset request; 1 forces and holds the sequence
//   rst_o    out  [NUM_STAGES] per-stage reset, active-high, bit k -> stage k
//   stage_o  out  number of stages currently released (0 .. NUM_STAGES)
//   busy_o   out  1 whenever the FSM is not in IDLE
//   done_o   out  one-cycle pulse when the last stage releases
//
// Optional feature macro: RESET_SEQ_REQ_SYNC_EN
//   defined   : req_i goes through a 2-flop synchronizer (+2 cycles latency)
//   undefined : req_i used directly, must be synchronous to clk
//
// States:
//   state      | meaning
//   ST_HOLD    | all stages asserted, counting the hold window
//   ST_RELEASE | some stages released, counting the gap to the next release
//   ST_IDLE    | every stage released, waiting for a request
// -----------------------------------------------------------------------------
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int CNT_W       = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_i,
   output logic [NUM_STAGES-1:0]             rst_o,
   output logic [stage_w(NUM_STAGES)-1:0]    stage_o,
   output logic                              busy_o,
   output logic                              done_o
);

   localparam int STAGE_W = stage_w(NUM_STAGES);

   localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [STAGE_W-1:0] LAST_IDX   = STAGE_W'(NUM_STAGES - 1);
   localparam logic [STAGE_W-1:0] ALL_STAGES = STAGE_W'(NUM_STAGES);

   // Elaboration-time parameter sanity.
   if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
      $error("reset_sequencer: NUM_STAGES out of range 1..16");
   end
   if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
      $error("reset_sequencer: HOLD_CYCLES and GAP_CYCLES must be at least 1");
   end
   if ((64'd1 << CNT_W) <= 64'(HOLD_CYCLES) || (64'd1 << CNT_W) <= 64'(GAP_CYCLES)) begin : g_bad_cnt_w
      $error("reset_sequencer: CNT_W too narrow for HOLD_CYCLES/GAP_CYCLES");
   end

   // ---------------------------------------------------------------------------
   // Request path
   // ---------------------------------------------------------------------------
   logic req_fsm;

`ifdef RESET_SEQ_REQ_SYNC_EN
   sync_2ff u_req_sync (
      .clk (clk),
      .rst (rst),
      .d_i (req_i),
      .q_o (req_fsm)
   );
`else
   assign req_fsm = req_i;
`endif

   // ---------------------------------------------------------------------------
   // Sequencer state
   // ---------------------------------------------------------------------------
   seq_state_e              state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic [NUM_STAGES-1:0]   rst_q;
   logic [STAGE_W-1:0]      stage_q;
   logic [STAGE_W-1:0]      stage_d;
   logic                    busy_q;
   logic                    done_q;

   assign cnt_d   = cnt_q + CNT_W'(1);
   assign stage_d = stage_q + STAGE_W'(1);

   // Releases always happen lowest index first, so shifting a zero in from the
   // LSB clears exactly the next stage and can never clear two at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         rst_q   <= '1;
         stage_q <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else if (req_fsm) begin
         // Same action from every state: restart (or abort into) the hold
         // window and keep the counter parked while the request is high.
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         rst_q   <= '1;
         stage_q <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_q   <= '0;
                  rst_q   <= rst_q << 1;
                  stage_q <= stage_d;
                  if (NUM_STAGES == 1) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  rst_q   <= rst_q << 1;
                  stage_q <= stage_d;
                  if (stage_q == LAST_IDX) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_IDLE: begin
               cnt_q   <= '0;
               rst_q   <= '0;
               stage_q <= ALL_STAGES;
               busy_q  <= 1'b0;
            end

            default: begin
               // Unreachable encoding: fall back to a full, safe re-sequence.
               state_q <= ST_HOLD;
               cnt_q   <= '0;
               rst_q   <= '1;
               stage_q <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign rst_o   = rst_q;
   assign stage_o = stage_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Self-checking bench for reset_sequencer. Two instances: the default
// 4-stage configuration and a 1-stage / 1-cycle-hold configuration whose
// request latency depends on RESET_SEQ_REQ_SYNC_EN.
// Each test pushes the expected output events (edge number, rst_o, stage_o,
// done_o) into a queue; a monitor pops and compares whenever rst_o changes or
// done_o is high.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

`ifdef RESET_SEQ_REQ_SYNC_EN
   localparam int REQ_LAT = 3;
`else
   localparam int REQ_LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [3:0] rst_o;
   logic [2:0] stage_o;
   logic       busy_o;
   logic       done_o;

   logic       rst1;
   logic       req1;
   logic [0:0] rst1_o;
   logic [0:0] stage1_o;
   logic       busy1_o;
   logic       done1_o;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_STAGES  (4),
      .HOLD_CYCLES (16),
      .GAP_CYCLES  (8),
      .CNT_W       (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req),
      .rst_o   (rst_o),
      .stage_o (stage_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   reset_sequencer #(
      .NUM_STAGES  (1),
      .HOLD_CYCLES (1),
      .GAP_CYCLES  (1),
      .CNT_W       (2)
   ) dut1 (
      .clk     (clk),
      .rst     (rst1),
      .req_i   (req1),
      .rst_o   (rst1_o),
      .stage_o (stage1_o),
      .busy_o  (busy1_o),
      .done_o  (done1_o)
   );

   typedef struct {
      int         edge_n;
      logic [3:0] rst;
      logic [2:0] stage;
      logic       done;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        exp1_q[$];
   int         edge_n   = 0;
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         sb_en    = 1'b0;
   bit         sb1_en   = 1'b0;
   logic [3:0] prev_rst;
   logic       prev_rst1;

   always @(posedge clk) edge_n++;

   // Scoreboard monitor, 4-stage instance.
   always @(negedge clk) begin
      ev_t e;
      if (sb_en && (rst_o !== prev_rst || done_o === 1'b1)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: edge %0d rst_o=%b stage_o=%0d done_o=%b, required no event",
                     edge_n, rst_o, stage_o, done_o);
         end else begin
            e = exp_q.pop_front();
            if (edge_n != e.edge_n || rst_o !== e.rst || stage_o !== e.stage || done_o !== e.done) begin
               n_fail++;
               $display("FAIL sb_event: edge %0d rst_o=%b stage_o=%0d done_o=%b, required edge %0d rst_o=%b stage_o=%0d done_o=%b",
                        edge_n, rst_o, stage_o, done_o, e.edge_n, e.rst, e.stage, e.done);
            end
         end
      end
      prev_rst = rst_o;
   end

   // Scoreboard monitor, 1-stage instance.
   always @(negedge clk) begin
      ev_t e;
      if (sb1_en && (rst1_o[0] !== prev_rst1 || done1_o === 1'b1)) begin
         n_checks++;
         if (exp1_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb1_unexpected: edge %0d rst_o=%b stage_o=%0d done_o=%b, required no event",
                     edge_n, rst1_o, stage1_o, done1_o);
         end else begin
            e = exp1_q.pop_front();
            if (edge_n != e.edge_n || {3'b000, rst1_o} !== e.rst ||
                {2'b00, stage1_o} !== e.stage || done1_o !== e.done) begin
               n_fail++;
               $display("FAIL sb1_event: edge %0d rst_o=%b stage_o=%0d done_o=%b, required edge %0d rst_o=%b stage_o=%0d done_o=%b",
                        edge_n, rst1_o, stage1_o, done1_o, e.edge_n, e.rst[0], e.stage, e.done);
            end
         end
      end
      prev_rst1 = rst1_o[0];
   end

   function automatic void push_ev(input int en, input logic [3:0] r, input logic [2:0] s, input logic d);
      ev_t e;
      e.edge_n = en;
      e.rst    = r;
      e.stage  = s;
      e.done   = d;
      exp_q.push_back(e);
   endfunction

   function automatic void push_ev1(input int en, input logic r, input logic s, input logic d);
      ev_t e;
      e.edge_n = en;
      e.rst    = {3'b000, r};
      e.stage  = {2'b00, s};
      e.done   = d;
      exp1_q.push_back(e);
   endfunction

   // Full default sequence, where base is the last edge that still saw the
   // request/reset high (so base+1 is E1).
   function automatic void push_seq(input int base);
      push_ev(base + 16, 4'b1110, 3'd1, 1'b0);
      push_ev(base + 24, 4'b1100, 3'd2, 1'b0);
      push_ev(base + 32, 4'b1000, 3'd3, 1'b0);
      push_ev(base + 40, 4'b0000, 3'd4, 1'b1);
   endfunction

   task automatic wait_drain(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && exp1_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_stage(input logic [2:0] target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (stage_o === target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      int b;
      bit ok;
      rst  = 1'b1;
      req  = 1'b0;
      rst1 = 1'b1;
      req1 = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rst_o, stage_o, busy_o, done_o} !== {4'b1111, 3'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: rst_o=%b stage_o=%0d busy_o=%b done_o=%b, required 1111 0 1 0",
                  rst_o, stage_o, busy_o, done_o);
      end
      sb_en = 1'b1;
      b     = edge_n;
      rst   = 1'b0;
      push_seq(b);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         n_checks++;
         if (rst_o !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_hold_E%0d: rst_o=%b, required 1111", i, rst_o);
         end
      end
      wait_drain(100, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL reset_drain: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rst_o, stage_o, busy_o, done_o} !== {4'b0000, 3'd4, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_idle: rst_o=%b stage_o=%0d busy_o=%b done_o=%b, required 0000 4 0 0",
                  rst_o, stage_o, busy_o, done_o);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_req_idle();
      int b;
      bit ok;
      @(negedge clk);
      b   = edge_n;
      req = 1'b1;
      push_ev(b + 1, 4'b1111, 3'd0, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({rst_o, stage_o, busy_o} !== {4'b1111, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL req_idle_assert: rst_o=%b stage_o=%0d busy_o=%b, required 1111 0 1",
                  rst_o, stage_o, busy_o);
      end
      req = 1'b0;
      push_seq(edge_n);
      wait_drain(100, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL req_idle_drain: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || stage_o !== 3'd4) begin
         n_fail++;
         $display("FAIL req_idle_end: busy_o=%b stage_o=%0d, required 0 4", busy_o, stage_o);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_abort();
      int b;
      int r;
      bit ok;
      @(negedge clk);
      b   = edge_n;
      req = 1'b1;
      push_ev(b + 1, 4'b1111, 3'd0, 1'b0);
      @(negedge clk);
      req = 1'b0;
      r   = edge_n;
      push_ev(r + 16, 4'b1110, 3'd1, 1'b0);
      push_ev(r + 24, 4'b1100, 3'd2, 1'b0);
      wait_stage(3'd2, 100, ok);
      n_checks++;
      if (!ok || edge_n != r + 24) begin
         n_fail++;
         $display("FAIL abort_reach_stage2: edge %0d stage_o=%0d, required edge %0d stage_o=2",
                  edge_n, stage_o, r + 24);
      end
      req = 1'b1;
      push_ev(edge_n + 1, 4'b1111, 3'd0, 1'b0);
      @(negedge clk);
      req = 1'b0;
      push_seq(edge_n);
      wait_drain(100, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL abort_drain: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_held_req();
      int b;
      int bad;
      bit ok;
      @(negedge clk);
      b   = edge_n;
      req = 1'b1;
      push_ev(b + 1, 4'b1111, 3'd0, 1'b0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ({rst_o, stage_o, busy_o} !== {4'b1111, 3'd0, 1'b1}) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL held_req_stays: %0d cycles not at 1111/0/busy, required 0", bad);
      end
      req = 1'b0;
      push_seq(edge_n);
      wait_drain(100, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL held_req_drain: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_rst_mid_release();
      int b;
      int r;
      bit ok;
      @(negedge clk);
      b   = edge_n;
      req = 1'b1;
      push_ev(b + 1, 4'b1111, 3'd0, 1'b0);
      @(negedge clk);
      req = 1'b0;
      r   = edge_n;
      push_ev(r + 16, 4'b1110, 3'd1, 1'b0);
      push_ev(r + 24, 4'b1100, 3'd2, 1'b0);
      push_ev(r + 32, 4'b1000, 3'd3, 1'b0);
      wait_stage(3'd3, 100, ok);
      n_checks++;
      if (!ok || edge_n != r + 32) begin
         n_fail++;
         $display("FAIL rst_mid_reach_stage3: edge %0d stage_o=%0d, required edge %0d stage_o=3",
                  edge_n, stage_o, r + 32);
      end
      rst = 1'b1;
      push_ev(edge_n + 1, 4'b1111, 3'd0, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({rst_o, stage_o, busy_o, done_o} !== {4'b1111, 3'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_mid_values: rst_o=%b stage_o=%0d busy_o=%b done_o=%b, required 1111 0 1 0",
                  rst_o, stage_o, busy_o, done_o);
      end
      @(negedge clk);
      rst = 1'b0;
      push_seq(edge_n);
      wait_drain(100, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rst_mid_drain: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_single_stage();
      int b;
      bit ok;
      @(negedge clk);
      n_checks++;
      if ({rst1_o, stage1_o, busy1_o, done1_o} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL single_reset_values: rst_o=%b stage_o=%0d busy_o=%b done_o=%b, required 1 0 1 0",
                  rst1_o, stage1_o, busy1_o, done1_o);
      end
      sb1_en = 1'b1;
      b      = edge_n;
      rst1   = 1'b0;
      push_ev1(b + 1, 1'b0, 1'b1, 1'b1);
      wait_drain(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_power_drain: %0d events outstanding, required 0", exp1_q.size());
         exp1_q.delete();
      end
      repeat (3) @(negedge clk);
      b    = edge_n;
      req1 = 1'b1;
      push_ev1(b + REQ_LAT,     1'b1, 1'b0, 1'b0);
      push_ev1(b + REQ_LAT + 1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      req1 = 1'b0;
      wait_drain(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_req_drain: %0d events outstanding, required 0", exp1_q.size());
         exp1_q.delete();
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rst1_o, stage1_o, busy1_o, done1_o} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL single_idle: rst_o=%b stage_o=%0d busy_o=%b done_o=%b, required 0 1 0 0",
                  rst1_o, stage1_o, busy1_o, done1_o);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_req_idle();
      test_abort();
      test_held_req();
      test_rst_mid_release();
      test_single_stage();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
